// File: rtl/box_draw_arbiter.sv
// box_draw_arbiter
// Shares one box drawer between four box-descriptor sources (erase, left
// paddle, right paddle, ball). One descriptor is accepted at a time over
// per-requester valid/ready, then forwarded on a registered valid/ready
// master port. No new grant is issued until the drawer has taken the box and
// shown ready again.
//
// Ports:
//   clock, reset_n        clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is combinational)
//   req_box_*             packed descriptors, requester i at [W*i +: W]
//   m_valid/m_ready       master handshake toward the box drawer
//   out_box_*             forwarded descriptor (registered)
//   grant_id              index of the requester last accepted
//   busy                  high while in SEND or WAIT
module box_draw_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned COORD_W     = 9,
  parameter int unsigned COLOR_W     = 3,
  parameter bit          HIGH_PRIO_0 = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*COORD_W-1:0] req_box_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_box_y,
  input  logic [NUM_REQ*COORD_W-1:0] req_box_w,
  input  logic [NUM_REQ*COORD_W-1:0] req_box_h,
  input  logic [NUM_REQ*COLOR_W-1:0] req_box_color,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [COORD_W-1:0]         out_box_x,
  output logic [COORD_W-1:0]         out_box_y,
  output logic [COORD_W-1:0]         out_box_w,
  output logic [COORD_W-1:0]         out_box_h,
  output logic [COLOR_W-1:0]         out_box_color,
  output logic [1:0]                 grant_id,
  output logic                       busy
);

  // Index width is fixed at 2 because the block is sized for four requesters;
  // the round-robin modulo relies on the natural 2-bit wrap.
  localparam int unsigned IDX_W = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]         state_q,      state_d;
  logic               m_valid_q,    m_valid_d;
  logic [COORD_W-1:0] x_q,          x_d;
  logic [COORD_W-1:0] y_q,          y_d;
  logic [COORD_W-1:0] w_q,          w_d;
  logic [COORD_W-1:0] h_q,          h_d;
  logic [COLOR_W-1:0] color_q,      color_d;
  logic [IDX_W-1:0]   grant_id_q,   grant_id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               busy_q,       busy_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

  // Winner selection: optional fixed priority for requester 0, otherwise
  // first valid index after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (HIGH_PRIO_0 && req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = last_grant_q + IDX_W'(k);
        if (!win_found && req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // Accept is offered only in IDLE, and only to the winner.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    m_valid_d    = m_valid_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    color_d      = color_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
              x_d     = req_box_x[i*COORD_W +: COORD_W];
              y_d     = req_box_y[i*COORD_W +: COORD_W];
              w_d     = req_box_w[i*COORD_W +: COORD_W];
              h_d     = req_box_h[i*COORD_W +: COORD_W];
              color_d = req_box_color[i*COLOR_W +: COLOR_W];
            end
          end
          grant_id_d   = win_idx;
          last_grant_d = win_idx;
          m_valid_d    = 1'b1;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // At least one cycle here covers the drawer's ready-deassert lag.
        if (m_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      m_valid_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      color_q      <= '0;
      grant_id_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_valid_q    <= m_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      color_q      <= color_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign m_valid       = m_valid_q;
  assign out_box_x     = x_q;
  assign out_box_y     = y_q;
  assign out_box_w     = w_q;
  assign out_box_h     = h_q;
  assign out_box_color = color_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_box_draw_arbiter.sv
// Bench for box_draw_arbiter: one round-robin instance and one with
// requester-0 priority, driven from shared inputs.
module tb_box_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic        m_ready;
  logic [8:0]  bx [4];
  logic [8:0]  by [4];
  logic [8:0]  bw [4];
  logic [8:0]  bh [4];
  logic [2:0]  bc [4];
  logic [35:0] req_box_x, req_box_y, req_box_w, req_box_h;
  logic [11:0] req_box_color;

  logic [3:0] rr_req_ready, pr_req_ready;
  logic       rr_m_valid, pr_m_valid;
  logic [8:0] rr_x, rr_y, rr_w, rr_h, pr_x, pr_y, pr_w, pr_h;
  logic [2:0] rr_c, pr_c;
  logic [1:0] rr_gid, pr_gid;
  logic       rr_busy, pr_busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] w;
    logic [8:0] h;
    logic [2:0] c;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_pr[$];

  always #5 clock = ~clock;

  assign req_box_x     = {bx[3], bx[2], bx[1], bx[0]};
  assign req_box_y     = {by[3], by[2], by[1], by[0]};
  assign req_box_w     = {bw[3], bw[2], bw[1], bw[0]};
  assign req_box_h     = {bh[3], bh[2], bh[1], bh[0]};
  assign req_box_color = {bc[3], bc[2], bc[1], bc[0]};

  box_draw_arbiter #(.NUM_REQ(4), .COORD_W(9), .COLOR_W(3), .HIGH_PRIO_0(1'b0)) u_rr (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rr_req_ready),
    .req_box_x(req_box_x), .req_box_y(req_box_y), .req_box_w(req_box_w),
    .req_box_h(req_box_h), .req_box_color(req_box_color),
    .m_valid(rr_m_valid), .m_ready(m_ready),
    .out_box_x(rr_x), .out_box_y(rr_y), .out_box_w(rr_w), .out_box_h(rr_h),
    .out_box_color(rr_c), .grant_id(rr_gid), .busy(rr_busy)
  );

  box_draw_arbiter #(.NUM_REQ(4), .COORD_W(9), .COLOR_W(3), .HIGH_PRIO_0(1'b1)) u_pr (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(pr_req_ready),
    .req_box_x(req_box_x), .req_box_y(req_box_y), .req_box_w(req_box_w),
    .req_box_h(req_box_h), .req_box_color(req_box_color),
    .m_valid(pr_m_valid), .m_ready(m_ready),
    .out_box_x(pr_x), .out_box_y(pr_y), .out_box_w(pr_w), .out_box_h(pr_h),
    .out_box_color(pr_c), .grant_id(pr_gid), .busy(pr_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int i);
    exp_t e;
    e.id = 2'(i);
    e.x  = bx[i];
    e.y  = by[i];
    e.w  = bw[i];
    e.h  = bh[i];
    e.c  = bc[i];
    return e;
  endfunction

  // Scoreboard pop on each master handshake about to happen at the next edge.
  task automatic mon();
    exp_t e;
    if (rr_m_valid === 1'b1 && m_ready === 1'b1) begin
      chk("rr_sb_nonempty", 32'(q_rr.size() != 0), 32'd1);
      if (q_rr.size() != 0) begin
        e = q_rr.pop_front();
        chk("rr_gid", 32'(rr_gid), 32'(e.id));
        chk("rr_x",   32'(rr_x),   32'(e.x));
        chk("rr_y",   32'(rr_y),   32'(e.y));
        chk("rr_w",   32'(rr_w),   32'(e.w));
        chk("rr_h",   32'(rr_h),   32'(e.h));
        chk("rr_c",   32'(rr_c),   32'(e.c));
      end
    end
    if (pr_m_valid === 1'b1 && m_ready === 1'b1) begin
      chk("pr_sb_nonempty", 32'(q_pr.size() != 0), 32'd1);
      if (q_pr.size() != 0) begin
        e = q_pr.pop_front();
        chk("pr_gid", 32'(pr_gid), 32'(e.id));
        chk("pr_x",   32'(pr_x),   32'(e.x));
        chk("pr_y",   32'(pr_y),   32'(e.y));
        chk("pr_w",   32'(pr_w),   32'(e.w));
        chk("pr_h",   32'(pr_h),   32'(e.h));
        chk("pr_c",   32'(pr_c),   32'(e.c));
      end
    end
  endtask

  task automatic settle();
    @(negedge clock);
    mon();
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    settle(); adv();
    settle(); adv();
    reset_n = 1'b1;
    q_rr.delete();
    q_pr.delete();
  endtask

  // One full accept/SEND/WAIT round with m_ready high; er/ep are the
  // expected winners of the round-robin and priority instances.
  task automatic round(input logic [3:0] v, input int er, input int ep);
    logic [3:0] oh_r, oh_p;
    oh_r = 4'(1 << er);
    oh_p = 4'(1 << ep);
    req_valid = v;
    settle();
    chk("rr_ready_idle", 32'(rr_req_ready), 32'(oh_r));
    chk("pr_ready_idle", 32'(pr_req_ready), 32'(oh_p));
    q_rr.push_back(mk(er));
    q_pr.push_back(mk(ep));
    adv();
    settle();
    chk("rr_mvalid_send", 32'(rr_m_valid), 32'd1);
    chk("pr_mvalid_send", 32'(pr_m_valid), 32'd1);
    chk("rr_busy_send",   32'(rr_busy),    32'd1);
    chk("rr_ready_send",  32'(rr_req_ready), 32'd0);
    chk("pr_ready_send",  32'(pr_req_ready), 32'd0);
    adv();
    settle();
    chk("rr_mvalid_wait", 32'(rr_m_valid), 32'd0);
    chk("rr_busy_wait",   32'(rr_busy),    32'd1);
    chk("rr_ready_wait",  32'(rr_req_ready), 32'd0);
    chk("pr_ready_wait",  32'(pr_req_ready), 32'd0);
    adv();
  endtask

  initial begin
    int exp_rr [5];
    int exp_pr [5];
    logic [3:0] vals [5];
    logic [8:0] held_x;

    for (int i = 0; i < 4; i++) begin
      bx[i] = 9'(40 + 60 * i);
      by[i] = 9'(20 + 7 * i);
      bw[i] = 9'(5 + i);
      bh[i] = 9'(8 + 3 * i);
      bc[i] = 3'(i + 2);
    end
    bx[1] = 9'd310; by[1] = 9'd96; bw[1] = 9'd10; bh[1] = 9'd48; bc[1] = 3'b111;
    req_valid = 4'b0000;
    m_ready   = 1'b1;

    // Reset then idle.
    do_reset();
    settle();
    chk("rst_rr_mvalid", 32'(rr_m_valid),   32'd0);
    chk("rst_rr_ready",  32'(rr_req_ready), 32'd0);
    chk("rst_rr_busy",   32'(rr_busy),      32'd0);
    chk("rst_rr_x",      32'(rr_x),         32'd0);
    chk("rst_rr_gid",    32'(rr_gid),       32'd0);
    chk("rst_pr_mvalid", 32'(pr_m_valid),   32'd0);
    chk("rst_pr_busy",   32'(pr_busy),      32'd0);
    adv();

    // Single request from requester 1.
    round(4'b0010, 1, 1);
    req_valid = 4'b0000;
    settle();
    chk("single_rr_busy_idle", 32'(rr_busy),    32'd0);
    chk("single_pr_busy_idle", 32'(pr_busy),    32'd0);
    chk("single_rr_mvalid",    32'(rr_m_valid), 32'd0);
    adv();

    // All requesting: round-robin 0,1,2,3,0 vs priority 0 always, 3 cycles apart.
    do_reset();
    exp_rr = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) round(4'b1111, exp_rr[k], 0);
    req_valid = 4'b0000;
    settle(); adv();

    // 1101 held, then requester 0 drops.
    do_reset();
    vals   = '{4'b1101, 4'b1101, 4'b1101, 4'b1100, 4'b1100};
    exp_rr = '{0, 2, 3, 2, 3};
    exp_pr = '{0, 0, 0, 2, 3};
    for (int k = 0; k < 5; k++) round(vals[k], exp_rr[k], exp_pr[k]);
    req_valid = 4'b0000;
    settle(); adv();

    // Drawer backpressure; descriptor change after accept must not leak out.
    req_valid = 4'b0001;
    m_ready   = 1'b0;
    settle();
    chk("bp_rr_ready", 32'(rr_req_ready), 32'd1);
    chk("bp_pr_ready", 32'(pr_req_ready), 32'd1);
    q_rr.push_back(mk(0));
    q_pr.push_back(mk(0));
    held_x = bx[0];
    adv();
    bx[0]     = 9'h1FF;
    req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      settle();
      chk("bp_rr_mvalid", 32'(rr_m_valid),   32'd1);
      chk("bp_rr_x",      32'(rr_x),         32'(held_x));
      chk("bp_rr_ready",  32'(rr_req_ready), 32'd0);
      chk("bp_pr_ready",  32'(pr_req_ready), 32'd0);
      adv();
    end
    req_valid = 4'b0000;
    m_ready   = 1'b1;
    settle();
    adv();
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_wait_mvalid", 32'(rr_m_valid), 32'd0);
      chk("bp_wait_busy",   32'(rr_busy),    32'd1);
      adv();
    end
    m_ready = 1'b1;
    settle();
    chk("bp_wait_busy_last", 32'(rr_busy), 32'd1);
    adv();
    settle();
    chk("bp_idle_busy", 32'(rr_busy), 32'd0);
    adv();
    bx[0] = held_x;

    // Reset while in SEND: descriptor is dropped, never re-issued.
    req_valid = 4'b0100;
    m_ready   = 1'b0;
    settle();
    chk("rs_rr_ready", 32'(rr_req_ready), 32'd4);
    chk("rs_pr_ready", 32'(pr_req_ready), 32'd4);
    adv();
    req_valid = 4'b0000;
    settle();
    chk("rs_rr_mvalid_pre", 32'(rr_m_valid), 32'd1);
    adv();
    reset_n = 1'b0;
    settle();
    adv();
    reset_n = 1'b1;
    m_ready = 1'b1;
    settle();
    chk("rs_rr_mvalid", 32'(rr_m_valid), 32'd0);
    chk("rs_rr_busy",   32'(rr_busy),    32'd0);
    chk("rs_rr_x",      32'(rr_x),       32'd0);
    chk("rs_rr_gid",    32'(rr_gid),     32'd0);
    chk("rs_pr_mvalid", 32'(pr_m_valid), 32'd0);
    adv();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rs_no_replay_rr", 32'(rr_m_valid), 32'd0);
      chk("rs_no_replay_pr", 32'(pr_m_valid), 32'd0);
      adv();
    end

    chk("rr_sb_drained", 32'(q_rr.size()), 32'd0);
    chk("pr_sb_drained", 32'(q_pr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
